// File: rtl/nexus_nonce_sequencer_if.sv
// Nonce issue / found-nonce bundle between the sequencer and its neighbours.
// master: sequencer side (drives hash_nonce/hash_issue and the found FIFO head);
// slave: hash pipeline + host side (drives keccak_qword, found_ready).
interface nexus_nonce_sequencer_if;
    logic [63:0] hash_nonce;
    logic        hash_issue;
    logic [63:0] keccak_qword;
    logic        found_valid;
    logic [63:0] found_nonce;
    logic        found_ready;

    modport master (
        output hash_nonce, hash_issue, found_valid, found_nonce,
        input  keccak_qword, found_ready
    );

    modport slave (
        input  hash_nonce, hash_issue, found_valid, found_nonce,
        output keccak_qword, found_ready
    );
endinterface

// File: rtl/nexus_nonce_sequencer.sv
// Nonce sequencer around the SK1024 pipeline: issues consecutive nonces,
// tracks in-flight slots, checks returned qwords against target, and queues winners.
// Ports: clk, nHashRst (sync, active-low), start/stop/run_en control,
// nonce_base/target work unit, pipe (hash + found FIFO bundle),
// busy/done/overflow status, hashes_done retire count.
module nexus_nonce_sequencer #(
    parameter int PIPE_LATENCY = 390,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      nHashRst,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      run_en,
    input  logic [63:0]               nonce_base,
    input  logic [63:0]               target,
    nexus_nonce_sequencer_if.master   pipe,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic [63:0]               hashes_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state, nextState;
    logic              issueNext, loadWork, doneNow;
    logic [PIPE_LATENCY-1:0] validLine;
    logic [63:0]       issueCnt, retireCnt, targetReg, issueBase;
    logic [63:0]       mem [FIFO_DEPTH];
    logic [AW:0]       wrPtr, rdPtr, fillLvl;
    logic              retire, win, pop, full, push;

    always_ff @(posedge clk) begin
        if (!nHashRst) state <= IDLE;
        else           state <= nextState;
    end

    // The registered issue strobe is decided from the next state, so the
    // first slot appears right after the start edge and none after stop.
    always_comb begin
        nextState = state;
        issueNext = 1'b0;
        loadWork  = 1'b0;
        doneNow   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    nextState = RUN;
                    loadWork  = 1'b1;
                    issueNext = run_en;
                end
            end
            RUN: begin
                if (stop) nextState = DRAIN;
                else      issueNext = run_en;
            end
            DRAIN: begin
                // An empty line also means nothing retires this cycle.
                if (validLine == '0) begin
                    nextState = IDLE;
                    doneNow   = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    assign retire    = validLine[PIPE_LATENCY-1];
    assign win       = retire && (pipe.keccak_qword <= targetReg);
    assign fillLvl   = wrPtr - rdPtr;
    assign full      = (fillLvl == FULL_LVL);
    assign pop       = pipe.found_valid && pipe.found_ready;
    assign push      = win && (!full || pop);
    assign issueBase = loadWork ? nonce_base : issueCnt;

    always_ff @(posedge clk) begin
        if (!nHashRst) begin
            validLine       <= '0;
            pipe.hash_issue <= 1'b0;
            pipe.hash_nonce <= '0;
            issueCnt        <= '0;
            retireCnt       <= '0;
            targetReg       <= '0;
            hashes_done     <= '0;
            overflow        <= 1'b0;
            wrPtr           <= '0;
            rdPtr           <= '0;
        end else begin
            validLine       <= {validLine[PIPE_LATENCY-2:0], pipe.hash_issue};
            pipe.hash_issue <= issueNext;
            if (issueNext) begin
                pipe.hash_nonce <= issueBase;
                issueCnt        <= issueBase + 64'd1;
            end else if (loadWork) begin
                issueCnt <= nonce_base;
            end
            if (loadWork) begin
                retireCnt   <= nonce_base;
                targetReg   <= target;
                hashes_done <= '0;
                overflow    <= 1'b0;
            end else begin
                if (retire) begin
                    retireCnt   <= retireCnt + 64'd1;
                    hashes_done <= hashes_done + 64'd1;
                end
                if (win && full && !pop) overflow <= 1'b1;
            end
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr[AW-1:0]] <= retireCnt;
    end

    assign pipe.found_valid = (wrPtr != rdPtr);
    assign pipe.found_nonce = pipe.found_valid ? mem[rdPtr[AW-1:0]] : '0;
    assign busy             = (state != IDLE);
    assign done             = doneNow;
endmodule

// File: tb/tb_nexus_nonce_sequencer.sv
// Bench for nexus_nonce_sequencer: delay-line hash model, winner scoreboard,
// table of qword/target boundary vectors plus hand-written corner sequences.
module tb_nexus_nonce_sequencer;
    localparam int LAT = 8;
    localparam int DEP = 4;

    logic        clk = 1'b0;
    logic        nHashRst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        run_en = 1'b0;
    logic [63:0] nonce_base = '0;
    logic [63:0] target = '0;
    logic        busy, done, overflow;
    logic [63:0] hashes_done;

    nexus_nonce_sequencer_if bus ();

    nexus_nonce_sequencer #(.PIPE_LATENCY(LAT), .FIFO_DEPTH(DEP)) dut (
        .clk         (clk),
        .nHashRst    (nHashRst),
        .start       (start),
        .stop        (stop),
        .run_en      (run_en),
        .nonce_base  (nonce_base),
        .target      (target),
        .pipe        (bus),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .hashes_done (hashes_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int doneCnt = 0;
    int issued = 0;
    logic [63:0] sb [$];

    // Behavioural pipeline: the nonce presented in cycle j comes back in j+LAT.
    logic [63:0] dly [LAT];
    logic [63:0] qtab [64];
    logic [63:0] curBase = '0;
    logic [63:0] offs;

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) dly[i] <= dly[i-1];
        dly[0] <= bus.hash_nonce;
    end

    assign offs = dly[LAT-1] - curBase;
    assign bus.keccak_qword = (offs < 64) ? qtab[offs[5:0]] : 64'hFFFF_FFFF_FFFF_FFFF;

    initial bus.found_ready = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) doneCnt++;
        if (bus.hash_issue) issued++;
        if (bus.found_valid && bus.found_ready) begin
            if (sb.size() == 0) chk("unexpected_pop", bus.found_nonce, 64'hx);
            else                chk("found_nonce", bus.found_nonce, sb.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fillQ(input logic [63:0] v);
        for (int i = 0; i < 64; i++) qtab[i] = v;
    endtask

    task automatic waitDone(input int n);
        for (int i = 0; i < 60 && busy; i++) tick();
        if (busy) chk("done_timeout", 64'(busy), 64'd0);
        chk("hashes_done", hashes_done, 64'(n));
        chk("done_pulses", 64'(doneCnt), 64'd1);
        chk("issued", 64'(issued), 64'(n));
    endtask

    task automatic drainFifo();
        bus.found_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() > 0; i++) tick();
        chk("sb_left", 64'(sb.size()), 64'd0);
        tick();
        chk("fifo_empty", 64'(bus.found_valid), 64'd0);
        bus.found_ready = 1'b0;
    endtask

    // n slots, then stop; a start during the drain must be ignored.
    task automatic runN(input logic [63:0] base, input logic [63:0] tgt, input int n);
        curBase = base;
        nonce_base = base;
        target = tgt;
        doneCnt = 0;
        issued = 0;
        start = 1'b1;
        run_en = 1'b1;
        tick();
        start = 1'b0;
        chk("first_nonce", bus.hash_nonce, base);
        for (int t = 1; t < n; t++) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("issue_off", 64'(bus.hash_issue), 64'd0);
        nonce_base = base + 64'd1000;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("drain_busy", 64'(busy), 64'd1);
        waitDone(n);
    endtask

    typedef struct {
        logic [63:0] qword;
        bit          win;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int firstT;
        int n;
        int seen;
        logic [63:0] hdAt;
        logic [63:0] base;

        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int firstT;
        int n;
        int seen;
        logic [63:0] hdAt;
        logic [63:0] base;

        vecs[0] = '{64'h0, 1'b1};
        vecs[1] = '{64'h0000_0000_FFFF_FFFF, 1'b1};
        vecs[2] = '{64'h0000_0001_0000_0000, 1'b0};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[4] = '{64'h1, 1'b1};
        vecs[5] = '{64'h8000_0000_0000_0000, 1'b0};
        vecs[6] = '{64'h0000_0000_FFFF_FFFE, 1'b1};
        vecs[7] = '{64'h0000_0001_0000_0001, 1'b0};

        fillQ('1);
        tick();
        tick();
        chk("rst_issue", 64'(bus.hash_issue), 64'd0);
        chk("rst_nonce", bus.hash_nonce, 64'd0);
        chk("rst_fvalid", 64'(bus.found_valid), 64'd0);
        chk("rst_fnonce", bus.found_nonce, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_hd", hashes_done, 64'd0);
        nHashRst = 1'b1;
        tick();

        // Single winner at base+5, found 14 cycles after start.
        base = 64'h0000_0001_FCAF_C044;
        fillQ('1);
        qtab[5] = 64'h0;
        sb.push_back(base + 64'd5);
        curBase = base;
        nonce_base = base;
        target = 64'h0000_0000_FFFF_FFFF;
        doneCnt = 0;
        issued = 0;
        firstT = -1;
        hdAt = '0;
        start = 1'b1;
        run_en = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_issue", 64'(bus.hash_issue), 64'd1);
        chk("t1_nonce", bus.hash_nonce, base);
        for (int t = 1; t <= 30; t++) begin
            stop = (t == 12);
            tick();
            if (bus.found_valid && firstT < 0) begin
                firstT = t;
                hdAt = hashes_done;
            end
        end
        stop = 1'b0;
        chk("t1_found_at", 64'(firstT), 64'd14);
        chk("t1_hd_at", hdAt, 64'd6);
        chk("t1_hd", hashes_done, 64'd12);
        chk("t1_done", 64'(doneCnt), 64'd1);
        chk("t1_busy", 64'(busy), 64'd0);
        drainFifo();

        // Boundary vectors: qword vs target, including equality.
        fillQ('1);
        base = 64'h0000_00AB_0000_0000;
        for (int i = 0; i < 8; i++) begin
            qtab[i] = vecs[i].qword;
            if (vecs[i].win) sb.push_back(base + 64'(i));
        end
        runN(base, 64'h0000_0000_FFFF_FFFF, 8);
        drainFifo();

        // Bubbles: run_en 1,0,0,1,... ; every slot wins and pops are consecutive.
        fillQ('1);
        base = 64'h0000_1234_0000_0000;
        curBase = base;
        nonce_base = base;
        target = '1;
        doneCnt = 0;
        issued = 0;
        bus.found_ready = 1'b1;
        start = 1'b1;
        run_en = 1'b1;
        sb.push_back(base);
        n = 1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 20; i++) begin
            run_en = (i % 4 == 0) || (i % 4 == 3);
            if (run_en) begin
                sb.push_back(base + 64'(n));
                n++;
            end
            tick();
        end
        run_en = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        run_en = 1'b1;
        waitDone(n);
        drainFifo();

        // 64-bit wrap of the nonce counters.
        base = 64'hFFFF_FFFF_FFFF_FFFE;
        for (int i = 0; i < 4; i++) sb.push_back(base + 64'(i));
        bus.found_ready = 1'b1;
        runN(base, '1, 4);
        drainFifo();

        // Six winners into a depth-4 FIFO with no pops.
        base = 64'h0000_0000_0000_5000;
        for (int i = 0; i < 4; i++) sb.push_back(base + 64'(i));
        runN(base, '1, 6);
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_fvalid", 64'(bus.found_valid), 64'd1);
        drainFifo();
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // Fifth winner on a full FIFO with a same-cycle pop is kept.
        base = 64'h0000_0000_0000_6000;
        for (int i = 0; i < 5; i++) sb.push_back(base + 64'(i));
        curBase = base;
        nonce_base = base;
        doneCnt = 0;
        issued = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ovf_cleared", 64'(overflow), 64'd0);
        for (int t = 1; t <= 24; t++) begin
            stop = (t == 5);
            bus.found_ready = (t == 13);
            tick();
        end
        stop = 1'b0;
        bus.found_ready = 1'b0;
        chk("pp_ovf", 64'(overflow), 64'd0);
        chk("pp_hd", hashes_done, 64'd5);
        chk("pp_done", 64'(doneCnt), 64'd1);
        drainFifo();

        // Reset with five slots in flight.
        base = 64'h0000_0000_0000_7000;
        curBase = base;
        nonce_base = base;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            stop = (t == 5);
            nHashRst = (t != 6);
            tick();
        end
        stop = 1'b0;
        nHashRst = 1'b1;
        chk("mr_issue", 64'(bus.hash_issue), 64'd0);
        chk("mr_nonce", bus.hash_nonce, 64'd0);
        chk("mr_fvalid", 64'(bus.found_valid), 64'd0);
        chk("mr_fnonce", bus.found_nonce, 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_done", 64'(done), 64'd0);
        chk("mr_ovf", 64'(overflow), 64'd0);
        chk("mr_hd", hashes_done, 64'd0);
        bus.found_ready = 1'b1;
        seen = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (bus.found_valid) seen++;
        end
        bus.found_ready = 1'b0;
        chk("mr_no_found", 64'(seen), 64'd0);
        chk("mr_hd_after", hashes_done, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
